cache_req_arbiter: RTL and testbench
====================================

CACHE_REQ_ARBITER -- requirements
Module: cache_req_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: maximum WAIT cycles before an outstanding request is abandoned.
REQ-002 SHALL have parameter CNT_W, default 16: width of the per-requester served counters.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports reqN_valid  input  1  request pending from requester N (N=0,1); held until reqN_ack.
REQ-006 SHALL have ports reqN_addr  input  32  byte address of the request.
REQ-007 SHALL have ports reqN_wdata  input  32  write data.
REQ-008 SHALL have ports reqN_rw  input  1  0=read, 1=write.
REQ-009 SHALL have ports reqN_ack  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports reqN_rdata  output  32  read data, valid while reqN_ack=1 and held until the next ack to N.
REQ-011 SHALL have ports c_address, c_data_in  output  32  request address and write data driven to the cache controller.
REQ-012 SHALL have port c_rw  output  1  request type driven to the cache controller.
REQ-013 SHALL have port c_active  output  1  high while a request is outstanding at the cache.
REQ-014 SHALL have port c_ready  input  1  cache completion pulse.
REQ-015 SHALL have port c_data_out  input  32  cache read data, sampled when c_ready=1.
REQ-016 SHALL have port timeout_err  output  1  sticky flag: set when any request timed out.
REQ-017 SHALL have ports servedN_cnt  output  CNT_W  saturating count of completed requests from requester N.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT and DONE; all outputs registered.
REQ-019 IDLE: when any reqN_valid=1, SHALL select a winner, latch its addr/wdata/rw into c_address/c_data_in/c_rw, record grant, clear timer and go to WAIT; otherwise SHALL remain in IDLE.
REQ-020 Selection SHALL be round-robin: if both requesters are valid, grant the one not equal to last_grant; if exactly one is valid, grant it.
REQ-021 WAIT: c_active=1; c_address/c_data_in/c_rw SHALL be held stable; the timer SHALL increment every cycle.
REQ-022 WAIT with c_ready=1: SHALL capture c_data_out into reqG_rdata for reads (leave it unchanged for writes), set last_grant=G, increment servedG_cnt (saturating at all-ones) and go to DONE.
REQ-023 WAIT with timer=TIMEOUT_CYCLES-1 and c_ready=0: SHALL set timeout_err, load reqG_rdata=32'hDEAD_BEEF, set last_grant=G without incrementing the counter, and go to DONE.
REQ-024 If c_ready=1 coincides with the timeout cycle, c_ready SHALL take precedence and timeout_err SHALL NOT be set.
REQ-025 DONE: SHALL pulse reqG_ack=1 for exactly one cycle, drive c_active=0, and return to IDLE; no grant is made in DONE (minimum one-cycle gap between transactions).
REQ-026 Latency: valid sampled in IDLE at cycle T -> c_active=1 at T+1; c_ready sampled at cycle R -> ack at R+1.
REQ-027 A reqN_valid deasserting during WAIT SHALL NOT abort the transaction; c_ready seen in IDLE or DONE SHALL be ignored.
REQ-028 At most one reqN_ack SHALL be high in any cycle; the ungranted requester's ack and rdata SHALL be unaffected.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, last_grant=1 (so requester 0 wins the first contention), and all outputs to 0 (acks, rdata, c_* outputs, c_active, timeout_err, counters), including mid-transaction; the aborted request receives no ack.

Verification
REQ-030 Single read: req0 valid, addr=32'h0000_1040, rw=0; c_ready after 3 WAIT cycles with c_data_out=32'h0000_1040 -> req0_ack one cycle later, req0_rdata=32'h0000_1040, served0_cnt=1.
REQ-031 Contention after reset: both valid simultaneously -> req0 granted first, req1 next (after the DONE gap); repeated contention alternates 0,1,0,1.
REQ-032 Timeout: req1 write, c_ready never asserted -> after 64 WAIT cycles: req1_ack=1, req1_rdata=32'hDEAD_BEEF, timeout_err=1 (stays 1), served1_cnt unchanged.
REQ-033 Timeout race: c_ready=1 on the 64th WAIT cycle -> normal completion, timeout_err=0.
REQ-034 Reset mid-WAIT: assert rst during WAIT -> c_active=0 and counters=0 immediately, no ack; after release, both valid -> req0 granted.
REQ-035 Saturation: with CNT_W=2, complete 5 req0 requests -> served0_cnt=3.

Source files
------------

// File: rtl/cache_req_arbiter.sv
// rtl/cache_req_arbiter.sv - two-requester round-robin arbiter in front of a single cache port
// Lets one request through to the cache at a time and gives up on it if the cache never answers.
module cache_req_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [31:0]      req0_addr,
  input  logic [31:0]      req0_wdata,
  input  logic             req0_rw,
  output logic             req0_ack,
  output logic [31:0]      req0_rdata,
  input  logic             req1_valid,
  input  logic [31:0]      req1_addr,
  input  logic [31:0]      req1_wdata,
  input  logic             req1_rw,
  output logic             req1_ack,
  output logic [31:0]      req1_rdata,
  output logic [31:0]      c_address,
  output logic [31:0]      c_data_in,
  output logic             c_rw,
  output logic             c_active,
  input  logic             c_ready,
  input  logic [31:0]      c_data_out,
  output logic             timeout_err,
  output logic [CNT_W-1:0] served0_cnt,
  output logic [CNT_W-1:0] served1_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        r_state;
  logic          r_grant;
  logic          r_last_grant;
  logic [TW-1:0] r_timer;

  // With both requesting, favour whoever did not finish last.
  logic w_any;
  logic w_pick1;
  logic w_timeout;
  assign w_any     = req0_valid | req1_valid;
  assign w_pick1   = req1_valid & (~req0_valid | ~r_last_grant);
  assign w_timeout = (r_timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_timer      <= '0;
      req0_ack     <= 1'b0;
      req1_ack     <= 1'b0;
      req0_rdata   <= '0;
      req1_rdata   <= '0;
      c_address    <= '0;
      c_data_in    <= '0;
      c_rw         <= 1'b0;
      c_active     <= 1'b0;
      timeout_err  <= 1'b0;
      served0_cnt  <= '0;
      served1_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant   <= w_pick1;
            c_address <= w_pick1 ? req1_addr  : req0_addr;
            c_data_in <= w_pick1 ? req1_wdata : req0_wdata;
            c_rw      <= w_pick1 ? req1_rw    : req0_rw;
            c_active  <= 1'b1;
            r_timer   <= '0;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A completion on the last allowed cycle wins over the timeout.
          if (c_ready || w_timeout) begin
            r_last_grant <= r_grant;
            c_active     <= 1'b0;
            r_state      <= S_DONE;
            if (!c_ready) timeout_err <= 1'b1;
            if (r_grant) begin
              req1_ack <= 1'b1;
              if (!c_ready)   req1_rdata <= 32'hDEAD_BEEF;
              else if (!c_rw) req1_rdata <= c_data_out;
              if (c_ready && !(&served1_cnt)) served1_cnt <= served1_cnt + CNT_W'(1);
            end else begin
              req0_ack <= 1'b1;
              if (!c_ready)   req0_rdata <= 32'hDEAD_BEEF;
              else if (!c_rw) req0_rdata <= c_data_out;
              if (c_ready && !(&served0_cnt)) served0_cnt <= served0_cnt + CNT_W'(1);
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_DONE: begin
          req0_ack <= 1'b0;
          req1_ack <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_req_arbiter.sv
// tb/tb_cache_req_arbiter.sv - directed self-checking bench for cache_req_arbiter
module tb_cache_req_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_rw, req1_valid, req1_rw, c_ready;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata, c_data_out;

  logic        req0_ack, req1_ack, c_rw, c_active, timeout_err;
  logic [31:0] req0_rdata, req1_rdata, c_address, c_data_in;
  logic [15:0] served0_cnt, served1_cnt;

  logic        s_req0_ack, s_req1_ack, s_c_rw, s_c_active, s_timeout_err;
  logic [31:0] s_req0_rdata, s_req1_rdata, s_c_address, s_c_data_in;
  logic [1:0]  s_served0_cnt, s_served1_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cache_req_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_rw(req0_rw),
    .req0_ack(req0_ack), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_rw(req1_rw),
    .req1_ack(req1_ack), .req1_rdata(req1_rdata),
    .c_address(c_address), .c_data_in(c_data_in), .c_rw(c_rw), .c_active(c_active),
    .c_ready(c_ready), .c_data_out(c_data_out), .timeout_err(timeout_err),
    .served0_cnt(served0_cnt), .served1_cnt(served1_cnt)
  );

  cache_req_arbiter #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_rw(req0_rw),
    .req0_ack(s_req0_ack), .req0_rdata(s_req0_rdata),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_rw(req1_rw),
    .req1_ack(s_req1_ack), .req1_rdata(s_req1_rdata),
    .c_address(s_c_address), .c_data_in(s_c_data_in), .c_rw(s_c_rw), .c_active(s_c_active),
    .c_ready(c_ready), .c_data_out(c_data_out), .timeout_err(s_timeout_err),
    .served0_cnt(s_served0_cnt), .served1_cnt(s_served1_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic serve(input logic [31:0] d, input int waits);
    for (int i = 0; i < waits; i++) step();
    c_ready = 1'b1;
    c_data_out = d;
    step();
    c_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 0; req0_rw = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_rw = 0; req1_addr = '0; req1_wdata = '0;
    c_ready = 0; c_data_out = '0;
    step(); step();
    chk("rst_c_active", c_active, 0);
    chk("rst_ack0", req0_ack, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_cnt0", served0_cnt, 0);
    chk("rst_addr", c_address, 0);
    rst = 1'b0;
    step();

    // single read
    req0_valid = 1; req0_addr = 32'h0000_1040; req0_rw = 0;
    step();
    chk("rd_active", c_active, 1);
    chk("rd_addr", c_address, 32'h0000_1040);
    chk("rd_rw", c_rw, 0);
    step(); step(); step();
    chk("rd_no_early_ack", req0_ack, 0);
    c_ready = 1; c_data_out = 32'h0000_1040;
    step();
    c_ready = 0; req0_valid = 0;
    chk("rd_ack", req0_ack, 1);
    chk("rd_ack1_quiet", req1_ack, 0);
    chk("rd_rdata", req0_rdata, 32'h0000_1040);
    chk("rd_cnt0", served0_cnt, 1);
    chk("rd_done_inactive", c_active, 0);
    step();
    chk("rd_ack_pulse", req0_ack, 0);

    // contention after reset alternates 0,1,0,1
    do_reset();
    req0_valid = 1; req0_addr = 32'h100; req0_rw = 0;
    req1_valid = 1; req1_addr = 32'h200; req1_rw = 0;
    step();
    chk("ct_grant0", c_address, 32'h100);
    serve(32'hAAAA, 1);
    chk("ct_ack0", req0_ack, 1);
    chk("ct_ack1_off", req1_ack, 0);
    chk("ct_rdata0", req0_rdata, 32'hAAAA);
    step();
    chk("ct_gap", c_active, 0);
    step();
    chk("ct_grant1", c_address, 32'h200);
    serve(32'hBBBB, 0);
    chk("ct_ack1", req1_ack, 1);
    chk("ct_rdata1", req1_rdata, 32'hBBBB);
    chk("ct_rdata0_kept", req0_rdata, 32'hAAAA);
    step(); step();
    chk("ct_grant0_again", c_address, 32'h100);
    serve(32'hCCCC, 0);
    chk("ct_ack0_again", req0_ack, 1);
    step(); step();
    chk("ct_grant1_again", c_address, 32'h200);
    serve(32'hDDDD, 0);
    chk("ct_ack1_again", req1_ack, 1);
    req0_valid = 0; req1_valid = 0;
    chk("ct_cnt0", served0_cnt, 2);
    chk("ct_cnt1", served1_cnt, 2);
    step();

    // timeout on a write from requester 1
    req1_valid = 1; req1_addr = 32'h300; req1_rw = 1; req1_wdata = 32'h5555;
    step();
    chk("to_rw", c_rw, 1);
    chk("to_wdata", c_data_in, 32'h5555);
    for (int i = 0; i < 63; i++) step();
    chk("to_not_yet", req1_ack, 0);
    chk("to_terr_not_yet", timeout_err, 0);
    chk("to_still_active", c_active, 1);
    step();
    req1_valid = 0;
    chk("to_ack", req1_ack, 1);
    chk("to_rdata", req1_rdata, 32'hDEAD_BEEF);
    chk("to_terr", timeout_err, 1);
    chk("to_cnt1", served1_cnt, 2);
    step();
    chk("to_terr_sticky", timeout_err, 1);

    // completion on the final allowed cycle beats the timeout
    do_reset();
    req0_valid = 1; req0_addr = 32'h400; req0_rw = 0;
    step();
    for (int i = 0; i < 63; i++) step();
    serve(32'h1234, 0);
    req0_valid = 0;
    chk("race_ack", req0_ack, 1);
    chk("race_rdata", req0_rdata, 32'h1234);
    chk("race_terr", timeout_err, 0);
    chk("race_cnt0", served0_cnt, 1);
    step();

    // c_ready in IDLE is ignored
    c_ready = 1; c_data_out = 32'h9999;
    step(); step();
    c_ready = 0;
    chk("idle_rdy_ack0", req0_ack, 0);
    chk("idle_rdy_cnt0", served0_cnt, 1);
    chk("idle_rdy_rdata", req0_rdata, 32'h1234);

    // reset mid-WAIT
    req1_valid = 1; req1_addr = 32'h500; req1_rw = 0;
    step();
    chk("mw_active", c_active, 1);
    step(); step();
    rst = 1;
    #1;
    chk("mw_active_clr", c_active, 0);
    chk("mw_cnt0_clr", served0_cnt, 0);
    chk("mw_addr_clr", c_address, 0);
    step();
    rst = 0;
    chk("mw_no_ack", req1_ack, 0);
    req0_valid = 1; req0_addr = 32'h100;
    step();
    chk("mw_grant0", c_address, 32'h100);
    serve(32'h7, 0);
    chk("mw_ack0", req0_ack, 1);
    req0_valid = 0; req1_valid = 0;
    step();

    // saturation of a 2-bit counter
    do_reset();
    req0_addr = 32'h600;
    for (int i = 0; i < 5; i++) begin
      req0_valid = 1;
      step();
      serve(32'h10 + i, 0);
      req0_valid = 0;
      step();
    end
    chk("sat_cnt_wide", served0_cnt, 5);
    chk("sat_cnt_narrow", s_served0_cnt, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
